seq_demux: RTL and testbench

Registered, handshaked successor to the combinational channel demux, used in the drum-machine trigger path. It routes one DATA_WIDTH word per accepted transaction to one of OUTPUT_WIDTH channel registers. Each write is either a latched hold value or a fixed-length pulse. Unselected channels keep their state rather than being forced to zero. A sequenced clear sweep zeroes all channels, one per cycle.

---
 rtl/seq_demux_if.sv | 35 +++
 rtl/seq_demux.sv | 138 +++++++++++++
 tb/tb_seq_demux.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_demux_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_demux_if
//  Brief    : Transaction, clear and channel-output bundle for seq_demux.
//             The master side issues routed writes and clear requests; the
//             slave side returns the channel registers and status flags.
//  Revision : 1.0  initial release
// ============================================================================
interface seq_demux_if #(
   parameter int DATA_WIDTH   = 8,
   parameter int OUTPUT_WIDTH = 8,
   parameter int SEL_WIDTH    = 3
);
   logic [DATA_WIDTH-1:0]   data_i;
   logic [SEL_WIDTH-1:0]    sel_i;
   logic                    mode_i;
   logic                    valid_i;
   logic                    ready_o;
   logic                    clear_i;
   logic [DATA_WIDTH-1:0]   data_o [OUTPUT_WIDTH];
   logic [OUTPUT_WIDTH-1:0] strobe_o;
   logic                    err_o;
   logic                    busy_o;

   modport master (
      output data_i, sel_i, mode_i, valid_i, clear_i,
      input  ready_o, data_o, strobe_o, err_o, busy_o
   );

   modport slave (
      input  data_i, sel_i, mode_i, valid_i, clear_i,
      output ready_o, data_o, strobe_o, err_o, busy_o
   );
endinterface
`default_nettype wire

// File: rtl/seq_demux.sv
`default_nettype none
// ============================================================================
//  Module   : seq_demux
//  Brief    : Registered, handshaked channel demux for the trigger path.
//             Each accepted word lands in one channel register either as a
//             held value or as a fixed-length pulse; a clear sweep zeroes
//             the channels one per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module seq_demux #(
   parameter int DATA_WIDTH   = 8,
   parameter int OUTPUT_WIDTH = 8,
   parameter int SEL_WIDTH    = 3,
   parameter int PULSE_CYCLES = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   seq_demux_if.slave bus
);
   localparam int c_cnt_w = $clog2(PULSE_CYCLES + 1);
   localparam int c_idx_w = $clog2(OUTPUT_WIDTH);
   localparam logic [c_cnt_w-1:0] c_pulse_load = c_cnt_w'(PULSE_CYCLES);
   localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
   localparam logic [c_idx_w-1:0] c_last_idx   = c_idx_w'(OUTPUT_WIDTH - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t                  r_state;
   logic [c_idx_w-1:0]      r_idx;
   logic                    r_busy;
   logic                    r_err;
   logic [OUTPUT_WIDTH-1:0] r_strobe;
   logic [OUTPUT_WIDTH-1:0] w_hit;
   logic [OUTPUT_WIDTH-1:0] w_sweep;
   logic                    w_ready;
   logic                    w_accept;

   // A clear request blocks acceptance in the same cycle, so clear beats valid.
   assign w_ready  = (r_state == ST_IDLE) && !bus.clear_i;
   assign w_accept = bus.valid_i && w_ready;

   // One-hot enables: the channel addressed by an accepted write, and the
   // channel currently under the clear sweep. Out-of-range selects hit nothing.
   always_comb begin
      w_hit   = '0;
      w_sweep = '0;
      for (int k = 0; k < OUTPUT_WIDTH; k++) begin
         if (w_accept && (bus.sel_i == SEL_WIDTH'(k))) begin
            w_hit[k] = 1'b1;
         end
         if ((r_state == ST_CLEAR) && (r_idx == c_idx_w'(k))) begin
            w_sweep[k] = 1'b1;
         end
      end
   end

   // Control FSM: sweep sequencing plus the registered busy and error flags.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_err <= w_accept && (w_hit == '0);
         case (r_state)
            ST_IDLE: begin
               if (bus.clear_i) begin
                  r_state <= ST_CLEAR;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               // clear_i is not looked at here: a running sweep never restarts.
               if (r_idx == c_last_idx) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // One-cycle write strobe for the addressed channel.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_strobe <= '0;
      end else begin
         r_strobe <= w_hit;
      end
   end

   generate
      for (genvar k = 0; k < OUTPUT_WIDTH; k++) begin : g_ch
         logic [DATA_WIDTH-1:0] r_data;
         logic [c_cnt_w-1:0]    r_cnt;

         // Channel register: sweep clear, then new write, then pulse countdown.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               r_data <= '0;
               r_cnt  <= '0;
            end else if (w_sweep[k]) begin
               r_data <= '0;
               r_cnt  <= '0;
            end else if (w_hit[k]) begin
               // A hold write zeroes the counter, cancelling any pending pulse;
               // a pulse write reloads it, which also covers retrigger.
               r_data <= bus.data_i;
               r_cnt  <= bus.mode_i ? c_pulse_load : '0;
            end else if (r_cnt != '0) begin
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == c_cnt_one) begin
                  r_data <= '0;
               end
            end
         end

         assign bus.data_o[k] = r_data;
      end
   endgenerate

   assign bus.ready_o  = w_ready;
   assign bus.strobe_o = r_strobe;
   assign bus.err_o    = r_err;
   assign bus.busy_o   = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_seq_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_demux
//  Brief    : Directed self-checking bench for seq_demux with six channels on
//             a 3-bit select, so selects 6 and 7 are out of range.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_demux;
   localparam int c_dw = 8;
   localparam int c_ow = 6;
   localparam int c_sw = 3;
   localparam int c_pc = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   int              checks = 0;
   int              errors = 0;
   logic [c_dw-1:0] exp_d [c_ow];

   seq_demux_if #(.DATA_WIDTH(c_dw), .OUTPUT_WIDTH(c_ow), .SEL_WIDTH(c_sw)) bus ();

   seq_demux #(
      .DATA_WIDTH   (c_dw),
      .OUTPUT_WIDTH (c_ow),
      .SEL_WIDTH    (c_sw),
      .PULSE_CYCLES (c_pc)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of sequence");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [c_sw-1:0] s, input logic m,
                        input logic [c_dw-1:0] d);
      bus.valid_i = v;
      bus.sel_i   = s;
      bus.mode_i  = m;
      bus.data_i  = d;
   endtask

   task automatic idle();
      drive(1'b0, 3'd0, 1'b0, 8'h00);
   endtask

   task automatic check_data(input string tag);
      for (int k = 0; k < c_ow; k++) begin
         check($sformatf("%s_d%0d", tag, k), 32'(bus.data_o[k]), 32'(exp_d[k]));
      end
   endtask

   task automatic check_flags(input string tag, input logic [c_ow-1:0] stb,
                              input logic err, input logic busy);
      check({tag, "_stb"},  32'(bus.strobe_o), 32'(stb));
      check({tag, "_err"},  32'(bus.err_o),    32'(err));
      check({tag, "_busy"}, 32'(bus.busy_o),   32'(busy));
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.clear_i = 1'b0;
      idle();
      for (int k = 0; k < c_ow; k++) exp_d[k] = 8'h00;

      // Reset values
      repeat (2) tick();
      check_data("rst");
      check_flags("rst", 6'h00, 1'b0, 1'b0);
      check("rst_ready", 32'(bus.ready_o), 32'd1);
      rst_n = 1'b1;
      tick();

      // Back-to-back hold writes
      drive(1'b1, 3'd2, 1'b0, 8'h11);
      tick();
      exp_d[2] = 8'h11;
      check_data("hold1");
      check_flags("hold1", 6'h04, 1'b0, 1'b0);
      drive(1'b1, 3'd5, 1'b0, 8'h22);
      tick();
      exp_d[5] = 8'h22;
      check_data("hold2");
      check_flags("hold2", 6'h20, 1'b0, 1'b0);
      idle();
      tick();
      check_data("hold3");
      check_flags("hold3", 6'h00, 1'b0, 1'b0);

      // Pulse on ch0: 0xA5 for exactly c_pc cycles
      drive(1'b1, 3'd0, 1'b1, 8'hA5);
      tick();
      idle();
      exp_d[0] = 8'hA5;
      check_data("pulse0");
      check_flags("pulse0", 6'h01, 1'b0, 1'b0);
      for (int i = 1; i < c_pc; i++) begin
         tick();
         check_data($sformatf("pulse%0d", i));
         check("pulse_stb", 32'(bus.strobe_o), 32'd0);
      end
      tick();
      exp_d[0] = 8'h00;
      check_data("pulse_end");

      // Retrigger on ch1 two cycles after the first pulse
      drive(1'b1, 3'd1, 1'b1, 8'h33);
      tick();
      idle();
      exp_d[1] = 8'h33;
      check_data("rt0");
      tick();
      check_data("rt1");
      drive(1'b1, 3'd1, 1'b1, 8'h44);
      tick();
      idle();
      exp_d[1] = 8'h44;
      check_data("rt2");
      check_flags("rt2", 6'h02, 1'b0, 1'b0);
      for (int i = 1; i < c_pc; i++) begin
         tick();
         check_data($sformatf("rt2_%0d", i));
      end
      tick();
      exp_d[1] = 8'h00;
      check_data("rt_end");

      // Hold write cancels a running pulse on ch3
      drive(1'b1, 3'd3, 1'b1, 8'h66);
      tick();
      exp_d[3] = 8'h66;
      check_data("cancel0");
      drive(1'b1, 3'd3, 1'b0, 8'h55);
      tick();
      idle();
      exp_d[3] = 8'h55;
      check_data("cancel1");
      repeat (c_pc + 2) tick();
      check_data("cancel_late");

      // Out-of-range selects: error flag only, no channel change
      drive(1'b1, 3'd7, 1'b0, 8'hEE);
      #1;
      check("oor_ready", 32'(bus.ready_o), 32'd1);
      tick();
      check_data("oor7");
      check_flags("oor7", 6'h00, 1'b1, 1'b0);
      drive(1'b1, 3'd6, 1'b1, 8'hEE);
      tick();
      check_data("oor6");
      check_flags("oor6", 6'h00, 1'b1, 1'b0);
      idle();
      tick();
      check_flags("oor_done", 6'h00, 1'b0, 1'b0);

      // Fill every channel with 0xFF, then a pulse on ch5
      for (int k = 0; k < c_ow; k++) begin
         drive(1'b1, c_sw'(k), 1'b0, 8'hFF);
         tick();
         exp_d[k] = 8'hFF;
      end
      check_data("fill");
      drive(1'b1, 3'd5, 1'b1, 8'hAB);
      tick();
      exp_d[5] = 8'hAB;

      // Clear together with a valid write: the write must be refused
      bus.clear_i = 1'b1;
      drive(1'b1, 3'd1, 1'b0, 8'h12);
      #1;
      check("clr_ready_comb", 32'(bus.ready_o), 32'd0);
      tick();
      bus.clear_i = 1'b0;
      idle();
      check_data("sw0");
      check_flags("sw0", 6'h00, 1'b0, 1'b1);
      check("sw0_ready", 32'(bus.ready_o), 32'd0);
      for (int j = 1; j <= c_ow; j++) begin
         // A clear request mid-sweep must not restart the sweep.
         bus.clear_i = (j == 4);
         tick();
         for (int k = 0; k < c_ow; k++) begin
            if (k < j)       exp_d[k] = 8'h00;
            else if (k == 5) exp_d[k] = (j >= 3) ? 8'h00 : 8'hAB;
            else             exp_d[k] = 8'hFF;
         end
         check_data($sformatf("sw%0d", j));
         check($sformatf("sw%0d_busy", j), 32'(bus.busy_o), 32'(j < c_ow));
         check($sformatf("sw%0d_ready", j), 32'(bus.ready_o), 32'(j == c_ow));
      end
      bus.clear_i = 1'b0;
      tick();
      check_flags("sw_after", 6'h00, 1'b0, 1'b0);
      check_data("sw_after");

      // Asynchronous reset in the middle of a sweep with a pulse running
      drive(1'b1, 3'd2, 1'b0, 8'h5A);
      tick();
      drive(1'b1, 3'd4, 1'b1, 8'hC3);
      tick();
      idle();
      bus.clear_i = 1'b1;
      tick();
      bus.clear_i = 1'b0;
      tick();
      check("arst_pre_d4", 32'(bus.data_o[4]), 32'h0000_00C3);
      check("arst_pre_d2", 32'(bus.data_o[2]), 32'h0000_005A);
      check("arst_pre_busy", 32'(bus.busy_o), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < c_ow; k++) exp_d[k] = 8'h00;
      check_data("arst");
      check_flags("arst", 6'h00, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      #1;
      check("arst_rel_busy", 32'(bus.busy_o), 32'd0);
      check("arst_rel_ready", 32'(bus.ready_o), 32'd1);
      tick();
      check_data("arst_post");
      check_flags("arst_post", 6'h00, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
